pc_unit: RTL and testbench

//  Parametrised program-counter unit; the next generation of the plain PC register.

---
 rtl/pc_unit.sv | 105 ++++++++++
 tb/tb_pc_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with trap, return-address stack, redirect and stall
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter int              INSTR_BYTES  = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h100,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            call,
  input  logic            ret,
  input  logic            trap,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            fault
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);
  localparam logic [CW-1:0]   FULL_COUNT = CW'(RAS_DEPTH);

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   top_idx;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] seq_pc;
  logic            misaligned;
  logic            do_push;
  logic            do_pop;
  logic            do_swap;
  logic            fault_set;

  assign seq_pc     = pc + XLEN'(INSTR_BYTES);
  assign misaligned = |(redirect_target & ALIGN_MASK);
  assign ras_empty  = (count == '0);
  assign ras_full   = (count == FULL_COUNT);

  // Next-PC selection by fixed priority; also decides the RAS operation and fault.
  always_comb begin
    pc_next   = seq_pc;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    do_swap   = 1'b0;
    fault_set = 1'b0;
    if (trap) begin
      pc_next = TRAP_VECTOR;
    end else if (ret && ras_empty) begin
      pc_next   = TRAP_VECTOR;
      fault_set = 1'b1;
    end else if (ret) begin
      pc_next = ras_mem[top_idx];
      if (call) begin
        do_swap = 1'b1;
      end else begin
        do_pop = 1'b1;
      end
    end else if (redirect_valid && misaligned) begin
      pc_next   = TRAP_VECTOR;
      fault_set = 1'b1;
    end else if (redirect_valid) begin
      pc_next = redirect_target;
      do_push = call;
    end else if (stall) begin
      pc_next = pc;
    end
  end

  // PC, stack pointer/occupancy and fault pulse; a full push overwrites the oldest slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc      <= RESET_VECTOR;
      top_idx <= '0;
      count   <= '0;
      fault   <= 1'b0;
    end else begin
      pc    <= pc_next;
      fault <= fault_set;
      if (do_push) begin
        top_idx <= top_idx + PW'(1);
        if (!ras_full) begin
          count <= count + CW'(1);
        end
      end else if (do_pop) begin
        top_idx <= top_idx - PW'(1);
        count   <= count - CW'(1);
      end
    end
  end

  // Return-address storage; deliberately not reset, only occupancy is.
  always_ff @(posedge clk) begin
    if (do_push) begin
      ras_mem[top_idx + PW'(1)] <= seq_pc;
    end else if (do_swap) begin
      ras_mem[top_idx] <= seq_pc;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - scoreboard bench for pc_unit against a queue-based reference model
module tb_pc_unit;

  localparam logic [31:0] RESET_V = 32'h0000_0000;
  localparam logic [31:0] TRAP_V  = 32'h0000_0100;
  localparam int          DEPTH   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic        trap = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        ras_empty;
  logic        ras_full;
  logic        fault;

  pc_unit #(
    .XLEN(32), .INSTR_BYTES(4), .RESET_VECTOR(RESET_V), .TRAP_VECTOR(TRAP_V), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .call(call), .ret(ret), .trap(trap),
    .pc(pc), .pc_next(pc_next), .ras_empty(ras_empty), .ras_full(ras_full), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        empty;
    logic        full;
    logic        fault;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_ras[$];
  logic [31:0] m_pc;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: one clock of architectural behaviour, expectation queued for the monitor.
  task automatic step(input bit st, input bit rv, input logic [31:0] tg,
                      input bit cl, input bit rt, input bit tr);
    exp_t        e;
    logic [31:0] nxt;
    bit          f;
    f   = 1'b0;
    nxt = m_pc + 32'd4;
    if (tr) begin
      nxt = TRAP_V;
    end else if (rt && m_ras.size() == 0) begin
      nxt = TRAP_V;
      f   = 1'b1;
    end else if (rt) begin
      nxt = m_ras[m_ras.size()-1];
      if (cl) m_ras[m_ras.size()-1] = m_pc + 32'd4;
      else    void'(m_ras.pop_back());
    end else if (rv && (tg % 4) != 0) begin
      nxt = TRAP_V;
      f   = 1'b1;
    end else if (rv) begin
      nxt = tg;
      if (cl) begin
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
    end else if (st) begin
      nxt = m_pc;
    end
    m_pc    = nxt;
    e.pc    = nxt;
    e.empty = (m_ras.size() == 0);
    e.full  = (m_ras.size() == DEPTH);
    e.fault = f;
    sb.push_back(e);
  endtask

  task automatic cyc(input bit st, input bit rv, input logic [31:0] tg,
                     input bit cl, input bit rt, input bit tr);
    @(negedge clk);
    stall = st; redirect_valid = rv; redirect_target = tg; call = cl; ret = rt; trap = tr;
    step(st, rv, tg, cl, rt, tr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 32'h0, 0, 0, 0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: sample pc_next before the edge, then compare registered outputs after it.
  initial begin : monitor
    exp_t        e;
    logic [31:0] nxt_s;
    bit          have;
    forever begin
      @(negedge clk);
      #2;
      have  = (sb.size() != 0);
      nxt_s = pc_next;
      @(posedge clk);
      #1;
      if (have && sb.size() != 0) begin
        e = sb.pop_front();
        chk("pc_next", nxt_s, e.pc);
        chk("pc", pc, e.pc);
        chk("ras_empty", 32'(ras_empty), 32'(e.empty));
        chk("ras_full", 32'(ras_full), 32'(e.full));
        chk("fault", 32'(fault), 32'(e.fault));
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : driver
    bit          rv, cl, rt, st, tr;
    logic [31:0] tg;
    m_pc = RESET_V;
    repeat (2) @(negedge clk);
    chk("reset_pc", pc, RESET_V);
    chk("reset_empty", 32'(ras_empty), 32'd1);
    chk("reset_full", 32'(ras_full), 32'd0);
    chk("reset_fault", 32'(fault), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Sequential fetch, stall hold, redirect taken during stall.
    idle(2);
    cyc(1, 0, 32'h0, 0, 0, 0);
    cyc(1, 0, 32'h0, 0, 0, 0);
    cyc(1, 0, 32'h0, 0, 0, 0);
    cyc(1, 1, 32'h40, 0, 0, 0);
    // Call / return pair.
    cyc(0, 1, 32'h10, 0, 0, 0);
    cyc(0, 1, 32'h200, 1, 0, 0);
    idle(2);
    cyc(0, 0, 32'h0, 0, 1, 0);
    // Overfill the stack, then unwind past empty.
    for (int i = 0; i < 5; i++) cyc(0, 1, 32'h1000 + 32'(i) * 32'h100, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 32'h0, 0, 1, 0);
    // Misaligned redirect, then trap masking the same fault.
    cyc(0, 1, 32'h42, 0, 0, 0);
    cyc(0, 1, 32'h42, 1, 0, 1);
    idle(1);
    // Coroutine swap and call+ret on empty stack.
    cyc(0, 1, 32'h300, 1, 0, 0);
    cyc(0, 1, 32'h500, 1, 1, 0);
    cyc(0, 0, 32'h0, 0, 1, 0);
    cyc(0, 1, 32'h600, 1, 1, 0);
    // Address wrap.
    cyc(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      st = ($urandom_range(3) == 0);
      rv = ($urandom_range(3) == 0);
      cl = rv && ($urandom_range(1) == 0);
      rt = ($urandom_range(5) == 0);
      tr = ($urandom_range(31) == 0);
      if (rt && cl) rv = 1'b1;
      tg = $urandom();
      if ($urandom_range(7) != 0) tg = tg & 32'hFFFF_FFFC;
      cyc(st, rv, tg, cl, rt, tr);
    end

    // Asynchronous reset in the middle of a call.
    drain();
    cyc(0, 1, 32'h700, 1, 0, 0);
    cyc(0, 1, 32'h800, 1, 0, 0);
    drain();
    @(negedge clk);
    stall = 0; redirect_valid = 1; redirect_target = 32'h900; call = 1; ret = 0; trap = 0;
    #1 rst = 1'b0;
    #1;
    chk("midreset_pc", pc, RESET_V);
    chk("midreset_empty", 32'(ras_empty), 32'd1);
    chk("midreset_fault", 32'(fault), 32'd0);
    @(posedge clk);
    #1;
    chk("midreset_hold_pc", pc, RESET_V);
    redirect_valid = 0; call = 0;
    rst = 1'b1;
    m_pc = RESET_V;
    m_ras.delete();
    idle(2);
    cyc(0, 0, 32'h0, 0, 1, 0);
    for (int i = 0; i < 500; i++) begin
      rv = ($urandom_range(2) == 0);
      cl = rv && ($urandom_range(1) == 0);
      rt = ($urandom_range(4) == 0);
      if (rt && cl) rv = 1'b1;
      cyc($urandom_range(3) == 0, rv, $urandom() & 32'hFFFF_FFFC, cl, rt, 0);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
